// File: rtl/acc_blk_n_if.sv
// Sample/result handshake bundle for acc_blk_n: producer-side sample channel
// and consumer-side result channel grouped in one interface.
interface acc_blk_n_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned SW = 10
);
    logic [W-1:0]  din;
    logic          din_vld;
    logic          din_rdy;
    logic [SW-1:0] sum;
    logic          sum_vld;
    logic          sum_rdy;

    modport master (
        output din, din_vld, sum_rdy,
        input  din_rdy, sum, sum_vld
    );

    modport slave (
        input  din, din_vld, sum_rdy,
        output din_rdy, sum, sum_vld
    );
endinterface

// File: rtl/acc_blk_n.sv
// Block accumulator: sums LEN accepted samples into one handshaked result.
// Optional macro ACC_SAT_EN: saturate at 2^SW-1 instead of wrapping.
module acc_blk_n #(
    parameter int unsigned W    = 8,
    parameter int unsigned CNTW = 4,
    parameter int unsigned LEN  = 4,
    parameter int unsigned SW   = 10
) (
    input  logic            clk,
    input  logic            res,
    input  logic            clr,
    acc_blk_n_if.slave      bus,
    output logic [CNTW-1:0] cnt,
    output logic            ovf
);

    localparam logic [CNTW-1:0] LAST = CNTW'(LEN - 1);

    logic [SW-1:0]   acc_r;
    logic [SW-1:0]   sum_r;
    logic [CNTW-1:0] cnt_r;
    logic            sum_vld_r;
    logic            ovf_r;

    logic [SW-1:0]   acc_nxt_s;
    logic [SW-1:0]   sum_nxt_s;
    logic [CNTW-1:0] cnt_nxt_s;
    logic            sum_vld_nxt_s;
    logic            ovf_nxt_s;

    logic [SW:0]     add_s;
    logic [SW-1:0]   add_res_s;
    logic            last_s;
    logic            din_rdy_s;
    logic            accept_s;
    logic            xfer_s;

    assign last_s    = (cnt_r == LAST);
    // Stall only on the block's last sample while the previous result is still unclaimed.
    assign din_rdy_s = !clr && !(last_s && sum_vld_r && !bus.sum_rdy);
    assign accept_s  = bus.din_vld && din_rdy_s;
    assign xfer_s    = sum_vld_r && bus.sum_rdy;

    assign add_s = {1'b0, acc_r} + {{(SW + 1 - W){1'b0}}, bus.din};
`ifdef ACC_SAT_EN
    assign add_res_s = add_s[SW] ? {SW{1'b1}} : add_s[SW-1:0];
`else
    assign add_res_s = add_s[SW-1:0];
`endif

    // Next-state computation for accumulator, counter, result register and overflow flag.
    always_comb begin
        acc_nxt_s     = acc_r;
        sum_nxt_s     = sum_r;
        cnt_nxt_s     = cnt_r;
        sum_vld_nxt_s = sum_vld_r;
        ovf_nxt_s     = ovf_r;
        if (clr) begin
            acc_nxt_s     = {SW{1'b0}};
            sum_nxt_s     = {SW{1'b0}};
            cnt_nxt_s     = {CNTW{1'b0}};
            sum_vld_nxt_s = 1'b0;
            ovf_nxt_s     = 1'b0;
        end else begin
            if (xfer_s) begin
                sum_vld_nxt_s = 1'b0;
            end else begin
                sum_vld_nxt_s = sum_vld_r;
            end
            if (accept_s) begin
                if (add_s[SW]) begin
                    ovf_nxt_s = 1'b1;
                end else begin
                    ovf_nxt_s = ovf_r;
                end
                // A final accept overrides a same-edge transfer so the new result stays valid.
                if (last_s) begin
                    sum_nxt_s     = add_res_s;
                    sum_vld_nxt_s = 1'b1;
                    acc_nxt_s     = {SW{1'b0}};
                    cnt_nxt_s     = {CNTW{1'b0}};
                end else begin
                    acc_nxt_s = add_res_s;
                    cnt_nxt_s = cnt_r + CNTW'(1'b1);
                end
            end else begin
                acc_nxt_s = acc_r;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            acc_r     <= {SW{1'b0}};
            sum_r     <= {SW{1'b0}};
            cnt_r     <= {CNTW{1'b0}};
            sum_vld_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            acc_r     <= acc_nxt_s;
            sum_r     <= sum_nxt_s;
            cnt_r     <= cnt_nxt_s;
            sum_vld_r <= sum_vld_nxt_s;
            ovf_r     <= ovf_nxt_s;
        end
    end

    assign bus.din_rdy = din_rdy_s;
    assign bus.sum     = sum_r;
    assign bus.sum_vld = sum_vld_r;
    assign cnt         = cnt_r;
    assign ovf         = ovf_r;

endmodule
